// File: rtl/seven_segment_scan_scheduler.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_scheduler
//
// Time-multiplexes a shared w_digit-digit seven-segment display. Each digit
// owns a fixed slot of slot_cycles clocks. The first blank_cycles clocks of
// every slot are dead time: digit and abcdefgh are held at zero so the
// previous digit's pattern cannot ghost onto the next one. In the remainder
// of the slot the digit pattern is shown through a 16-level PWM. Digits
// masked off by digit_en still use their full slot, which keeps the refresh
// period fixed at w_digit*slot_cycles.
//
// Parameters:
//   clk_mhz      system clock frequency in MHz
//   w_digit      number of digits scanned
//   digit_hz     slot rate; slot_cycles = clk_mhz*1_000_000/digit_hz
//   blank_cycles dead-time cycles at the start of each slot
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   segments     abcdefgh pattern per digit, digit i at [8*i+7:8*i], 1 = lit
//   digit_en     per-digit enable mask, 1 = digit shown
//   brightness   0 = 1/16 duty ... 15 = always on
//   abcdefgh     active-high segment drive (registered)
//   digit        one-hot active-high digit select (registered)
//   frame_start  one-cycle pulse on the BLANK entry of slot 0 (registered)
//
// Build option:
//   SEVEN_SEGMENT_SCAN_FRAME_SNAPSHOT_EN
//     When defined, segments and digit_en are copied into shadow registers
//     at every frame_start and once right after reset release; every slot of
//     a frame then reads the shadow copy, so a frame is one coherent image.
//     When undefined, each slot latches the live inputs at its ON entry.
// -----------------------------------------------------------------------------
module seven_segment_scan_scheduler #(
  parameter int clk_mhz      = 100,
  parameter int w_digit      = 8,
  parameter int digit_hz     = 1000,
  parameter int blank_cycles = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*w_digit-1:0]   segments,
  input  logic [w_digit-1:0]     digit_en,
  input  logic [3:0]             brightness,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_start
);

  localparam int slot_cycles = clk_mhz * 1_000_000 / digit_hz;
  localparam int cw          = $clog2(slot_cycles);
  localparam int iw          = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [cw-1:0] last_cnt  = cw'(slot_cycles - 1);
  localparam logic [cw-1:0] blank_cnt = cw'(blank_cycles);
  localparam logic [iw-1:0] last_idx  = iw'(w_digit - 1);

  // Parameter sanity: the ON window must leave room for at least one full
  // PWM period, and every slot must start with at least one blank cycle.
  if (slot_cycles <= blank_cycles + 16) begin : g_bad_slot
    $error("seven_segment_scan_scheduler: slot_cycles must exceed blank_cycles + 16");
  end
  if (blank_cycles < 1) begin : g_bad_blank
    $error("seven_segment_scan_scheduler: blank_cycles must be at least 1");
  end
  if (w_digit < 1) begin : g_bad_width
    $error("seven_segment_scan_scheduler: w_digit must be at least 1");
  end

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t               state_reg;
  logic [cw-1:0]        cnt_reg;
  logic [iw-1:0]        idx_reg;
  logic [3:0]           pwm_reg;
  logic [7:0]           pat_reg;
  logic                 en_reg;
  logic [7:0]           abcdefgh_reg;
  logic [w_digit-1:0]   digit_reg;
  logic                 frame_start_reg;

  logic [cw-1:0]        cnt_next;
  logic [iw-1:0]        idx_next;
  logic [3:0]           pwm_next;
  logic                 cnt_wrap;
  logic                 frame_wrap;
  logic                 lit;

  // Pattern/enable source that the slots latch from.
  logic [8*w_digit-1:0]      seg_flat;
  logic [w_digit-1:0]        en_flat;
  logic [w_digit-1:0][7:0]   seg_src;
  logic [w_digit-1:0]        onehot;
  logic [7:0]                sel_pat;
  logic                      sel_en;

  always_comb begin
    cnt_wrap   = (cnt_reg == last_cnt);
    cnt_next   = cnt_wrap ? '0 : cnt_reg + 1'b1;
    frame_wrap = cnt_wrap && (idx_reg == last_idx);
    if (cnt_wrap) begin
      idx_next = (idx_reg == last_idx) ? '0 : idx_reg + 1'b1;
    end else begin
      idx_next = idx_reg;
    end
    pwm_next = pwm_reg + 4'd1;
    // The registered output shows the cycle that pwm_next belongs to.
    lit      = (pwm_next <= brightness);
    sel_pat  = seg_src[idx_reg];
    sel_en   = en_flat[idx_reg];
  end

  genvar gi;
  generate
    for (gi = 0; gi < w_digit; gi++) begin : g_digit
      assign seg_src[gi] = seg_flat[8*gi +: 8];
      assign onehot[gi]  = (idx_reg == iw'(gi));
    end
  endgenerate

`ifdef SEVEN_SEGMENT_SCAN_FRAME_SNAPSHOT_EN
  logic [8*w_digit-1:0] shadow_seg_reg;
  logic [w_digit-1:0]   shadow_en_reg;
  logic                 snap_armed_reg;

  // Capture on the first clock after reset release, then on every
  // frame_start edge, so slot 0's ON entry always sees a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_seg_reg <= '0;
      shadow_en_reg  <= '0;
      snap_armed_reg <= 1'b0;
    end else if (!snap_armed_reg || frame_wrap) begin
      shadow_seg_reg <= segments;
      shadow_en_reg  <= digit_en;
      snap_armed_reg <= 1'b1;
    end
  end

  assign seg_flat = shadow_seg_reg;
  assign en_flat  = shadow_en_reg;
`else
  assign seg_flat = segments;
  assign en_flat  = digit_en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BLANK;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      pwm_reg         <= '0;
      pat_reg         <= '0;
      en_reg          <= 1'b0;
      abcdefgh_reg    <= '0;
      digit_reg       <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      pwm_reg         <= pwm_next;
      frame_start_reg <= frame_wrap;
      case (state_reg)
        ST_BLANK: begin
          digit_reg    <= '0;
          abcdefgh_reg <= '0;
          // Entering ON: blank_cycles >= 1 guarantees the index does not
          // move on this edge, so idx_reg already names the new slot.
          if (cnt_next == blank_cnt) begin
            state_reg    <= ST_ON;
            pat_reg      <= sel_pat;
            en_reg       <= sel_en;
            digit_reg    <= sel_en ? onehot : '0;
            abcdefgh_reg <= (sel_en && lit) ? sel_pat : 8'h00;
          end
        end
        ST_ON: begin
          if (cnt_wrap) begin
            state_reg    <= ST_BLANK;
            digit_reg    <= '0;
            abcdefgh_reg <= '0;
          end else begin
            digit_reg    <= en_reg ? onehot : '0;
            // A disabled digit keeps the segment bus dark as well.
            abcdefgh_reg <= (en_reg && lit) ? pat_reg : 8'h00;
          end
        end
        default: begin
          state_reg    <= ST_BLANK;
          digit_reg    <= '0;
          abcdefgh_reg <= '0;
        end
      endcase
    end
  end

  assign abcdefgh    = abcdefgh_reg;
  assign digit       = digit_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_segment_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_scheduler
//
// Bench for seven_segment_scan_scheduler with clk_mhz=1, digit_hz=10000
// (slot_cycles=100), blank_cycles=4, w_digit=4. Cycle t is the period after
// the t-th rising edge following reset release (cycle 0 = before any edge).
// The reference model derives the expected outputs from t alone: slot
// position t%100, slot index (t/100)%4, pwm phase t%16, frame boundary
// t%400. Build with SEVEN_SEGMENT_SCAN_FRAME_SNAPSHOT_EN to match the
// snapshot variant of the design.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_scheduler;

  localparam int W     = 4;
  localparam int SLOT  = 100;
  localparam int BLANK = 4;
  localparam int FRAME = W * SLOT;

  logic             clk;
  logic             rst_n;
  logic [8*W-1:0]   segments;
  logic [W-1:0]     digit_en;
  logic [3:0]       brightness;
  logic [7:0]       abcdefgh;
  logic [W-1:0]     digit;
  logic             frame_start;

  seven_segment_scan_scheduler #(
    .clk_mhz      (1),
    .w_digit      (W),
    .digit_hz     (10000),
    .blank_cycles (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segments    (segments),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .abcdefgh    (abcdefgh),
    .digit       (digit),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference model state
  logic [8*W-1:0] prev_seg;
  logic [W-1:0]   prev_en;
  logic [3:0]     prev_br;
  logic [8*W-1:0] src_seg;
  logic [W-1:0]   src_en;
  logic [7:0]     lat_pat;
  logic           lat_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  // Advance one clock and compare all outputs with the model.
  task automatic step();
    int pos;
    int slot;
    logic [W-1:0] exp_d;
    logic [7:0]   exp_a;
    logic         exp_f;
    prev_seg = segments;
    prev_en  = digit_en;
    prev_br  = brightness;
    @(posedge clk);
    #1;
    t++;
`ifdef SEVEN_SEGMENT_SCAN_FRAME_SNAPSHOT_EN
    if (t == 1 || (t % FRAME) == 0) begin
      src_seg = prev_seg;
      src_en  = prev_en;
    end
`else
    src_seg = prev_seg;
    src_en  = prev_en;
`endif
    pos  = t % SLOT;
    slot = (t / SLOT) % W;
    if (pos == BLANK) begin
      lat_pat = src_seg[slot*8 +: 8];
      lat_en  = src_en[slot];
    end
    exp_d = (pos >= BLANK && lat_en) ? W'(1 << slot) : '0;
    exp_a = (pos >= BLANK && lat_en && (t % 16) <= int'(prev_br)) ? lat_pat : 8'h00;
    exp_f = ((t % FRAME) == 0);
    check("digit", 32'(digit), 32'(exp_d));
    check("abcdefgh", 32'(abcdefgh), 32'(exp_a));
    check("frame_start", 32'(frame_start), 32'(exp_f));
    check("digit_onehot0", 32'($onehot0(digit)), 32'd1);
    check("dark_when_no_digit", (digit == '0) ? 32'(abcdefgh) : 32'd0, 32'd0);
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  // Assert reset mid-cycle, verify outputs clear at once, release at negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_abcdefgh", 32'(abcdefgh), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    t       = 0;
    lat_pat = '0;
    lat_en  = 1'b0;
    src_seg = '0;
    src_en  = '0;
    #1;
    check("cycle0_digit", 32'(digit), 32'd0);
    check("cycle0_abcdefgh", 32'(abcdefgh), 32'd0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b1;
    segments   = '0;
    digit_en   = '0;
    brightness = '0;
    #2;

    // 1: basic scan at full brightness
    segments   = 32'hFF00_A53C;
    digit_en   = 4'hF;
    brightness = 4'd15;
    do_reset();
    run_to(3);
    check("t1_blank_c3", 32'(digit), 32'd0);
    run_to(4);
    check("t1_digit_c4", 32'(digit), 32'b0001);
    check("t1_seg_c4", 32'(abcdefgh), 32'h3C);
    run_to(104);
    check("t1_digit_c104", 32'(digit), 32'b0010);
    check("t1_seg_c104", 32'(abcdefgh), 32'hA5);
    run_to(810);
    $display("phase 1 basic scan: cycles=%0d bad=%0d", t, bad);

    // 2: digit 2 masked off
    digit_en = 4'b1011;
    do_reset();
    run_to(250);
    check("t2_masked_c250", 32'(digit), 32'd0);
    run_to(304);
    check("t2_slot3_c304", 32'(digit), 32'b1000);
    run_to(704);
    check("t2_slot3_c704", 32'(digit), 32'b1000);
    run_to(810);
    $display("phase 2 enable mask: cycles=%0d bad=%0d", t, bad);

    // 3: PWM duty
    segments   = 32'h0000_00FF;
    digit_en   = 4'hF;
    brightness = 4'd3;
    do_reset();
    n = 0;
    while (t < 99) begin
      step();
      if (abcdefgh == 8'hFF) n++;
    end
    check("t3_duty_b3", 32'(n), 32'd24);
    brightness = 4'd0;
    do_reset();
    n = 0;
    while (t < 99) begin
      step();
      if (abcdefgh == 8'hFF) n++;
    end
    check("t3_duty_b0", 32'(n), 32'd6);
    $display("phase 3 brightness: bad=%0d", bad);

    // 4: pattern changes mid-slot
    segments   = 32'h0000_003C;
    brightness = 4'd15;
    do_reset();
`ifdef SEVEN_SEGMENT_SCAN_FRAME_SNAPSHOT_EN
    run_to(99);
    check("t4_hold_c99", 32'(abcdefgh), 32'h3C);
    run_to(349);
    segments[7:0] = 8'h81;
    run_to(400);
    segments[7:0] = 8'h5A;
    run_to(404);
    check("t4_new_c404", 32'(abcdefgh), 32'h81);
    run_to(804);
    check("t4_new_c804", 32'(abcdefgh), 32'h5A);
`else
    run_to(49);
    segments[7:0] = 8'h81;
    run_to(99);
    check("t4_hold_c99", 32'(abcdefgh), 32'h3C);
    run_to(404);
    check("t4_new_c404", 32'(abcdefgh), 32'h81);
`endif
    $display("phase 4 latching: bad=%0d", bad);

    // 5: reset in the middle of slot 2's ON window
    segments = 32'hFF00_A53C;
    digit_en = 4'hF;
    do_reset();
    run_to(250);
    check("t5_before_rst", 32'(digit), 32'b0100);
    do_reset();
    run_to(3);
    check("t5_blank_c3", 32'(digit), 32'd0);
    run_to(4);
    check("t5_first_on", 32'(digit), 32'b0001);
    $display("phase 5 reset mid-slot: bad=%0d", bad);

    // 6: random inputs over ten frames
    do_reset();
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) segments = $urandom;
      if ($urandom_range(0, 15) == 0) digit_en = W'($urandom_range(0, 15));
      brightness = 4'($urandom_range(0, 15));
      step();
    end
    $display("phase 6 random: cycles=%0d bad=%0d", t, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_scheduler.md
Name: seven_segment_scan_scheduler

Overview:
Time-multiplexes a shared w_digit-digit seven-segment display between per-digit segment patterns supplied by lab logic.
- Sequences digit slots with a dead-time (blank) gap between digits to prevent ghosting.
- Applies a per-digit enable mask and 16-level brightness PWM.
- Sits between lab_top and the board top. The board top inverts abcdefgh and digit to match the polarity its display pins need.

Parameters:
clk_mhz, 100, system clock frequency in MHz
w_digit, 8, number of digits scanned
digit_hz, 1000, slot rate; slot_cycles = clk_mhz*1_000_000/digit_hz
blank_cycles, 64, dead-time cycles at the start of each slot; elaboration error unless slot_cycles > blank_cycles + 16

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
segments  in  8*w_digit  abcdefgh pattern per digit; digit i at bits [8*i+7:8*i]; 1 = segment lit
digit_en  in  w_digit  per-digit enable mask; 1 = digit shown
brightness  in  4  0 = 1/16 duty … 15 = full on
abcdefgh  out  8  active-high segment drive, registered
digit  out  w_digit  one-hot active-high digit select, registered
frame_start  out  1  one-cycle pulse when slot 0 begins

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: state BLANK, slot index 0, slot counter 0, pwm counter 0, abcdefgh = 0, digit = 0, frame_start = 0, latched pattern = 0.
- Slot counter:
  - Counts 0 .. slot_cycles-1, then wraps.
  - On wrap, index advances to (index+1) mod w_digit; index w_digit-1 wraps to 0.
- State BLANK (slot counter < blank_cycles):
  - digit = 0, abcdefgh = 0.
  - Transitions to ON when the counter reaches blank_cycles.
- Entry to ON:
  - Latch the pattern for the current index.
  - Sample digit_en[index] into en_q.
- State ON (counter blank_cycles .. slot_cycles-1):
  - digit = one-hot(index) if en_q, else 0.
  - abcdefgh = latched pattern while pwm_cnt <= brightness, else 0.
  - pwm_cnt is a free-running 4-bit counter that increments every cycle from reset.
  - brightness is sampled every cycle and is not latched.
- Transition ON -> BLANK on slot wrap.
- Latency: outputs change on the clock edge following the state change. The first ON output appears at cycle blank_cycles after rst_n deasserts, for digit 0.
- frame_start:
  - Pulses for one cycle on the clock edge where the index wraps from w_digit-1 to 0 (BLANK entry of slot 0).
  - Does not pulse after reset release.
- Enable mask behaviour:
  - Disabled digits still consume their full slot, so refresh period stays constant at w_digit*slot_cycles.
  - A digit_en change mid-slot takes effect at the next ON entry.
- segments change mid-ON: no effect until the slot is next entered (no tearing within a slot).
- Reset mid-slot: all outputs are zero asynchronously; the scan restarts at index 0, BLANK.
- Invariants:
  - digit is never multi-hot.
  - digit and abcdefgh are both zero throughout BLANK.

Optional Feature:
SEVEN_SEGMENT_SCAN_FRAME_SNAPSHOT_EN
- Defined:
  - The whole segments and digit_en vectors are captured into shadow registers at every frame_start, and also once at reset release.
  - Every slot in a frame uses the shadow copy, so all digits of a frame come from one coherent snapshot.
- Undefined: per-slot latching as described in Behaviour; no shadow registers are built.

Test Plan:
Common setup: clk_mhz=1, digit_hz=10000 (slot_cycles=100), blank_cycles=4, w_digit=4.

1. Reset release with segments=32'hFF_00_A5_3C, digit_en=4'hF, brightness=15:
   - Cycles 0-3: digit=0, abcdefgh=0.
   - Cycles 4-99: digit=4'b0001, abcdefgh=8'h3C.
   - Cycle 104: digit=4'b0010, abcdefgh=8'hA5.
   - frame_start pulses exactly once, at cycle 400, and every 400 cycles after.
2. digit_en=4'b1011, free run: digit is never 4'b0100; slot 2's 100 cycles all show digit=0; slot 3 still starts at cycle 300 + 4 within each frame.
3. brightness=3, segments digit0=8'hFF:
   - During ON, abcdefgh=8'hFF exactly when pwm_cnt ∈ {0..3}: 4 of every 16 cycles.
   - brightness=0 gives 1 of every 16.
4. Change segments digit0 from 8'h3C to 8'h81 at cycle 50:
   - Output holds 8'h3C until cycle 99.
   - 8'h81 appears from cycle 404.
   - With the feature macro defined: a change at cycle 350 appears at cycle 404, while a change at cycle 401 does not appear until cycle 804.
5. Assert rst_n=0 at cycle 250 (mid-ON of slot 2):
   - digit and abcdefgh go to 0 immediately.
   - After release, the first ON is digit 0, four cycles later.
6. Random segments/digit_en/brightness over 10 frames: assertions hold that digit is 0 or one-hot, and that abcdefgh=0 whenever digit=0.
